// File: rtl/dscrptr_req_sched_pkg.sv
// Shared types and helpers for the descriptor request scheduler.
package dscrptr_req_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        REQ       = 2'd2,
        WAIT_DONE = 2'd3
    } schedStateT;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dscrptr_req_sched_rr_pick.sv
// Round-robin picker: first eligible descriptor after rrPtr, rrPtr itself last.
module dscrptr_rr_pick
    import dscrptr_req_sched_pkg::*;
#(
    parameter int NUM_OF_BDS       = 4,
    parameter int NUM_OF_BDS_WIDTH = 2
) (
    input  logic [NUM_OF_BDS-1:0]       elig,
    input  logic [NUM_OF_BDS_WIDTH-1:0] rrPtr,
    output logic [NUM_OF_BDS_WIDTH-1:0] pickNum,
    output logic                        pickVld
);

    logic [NUM_OF_BDS-1:0]       rotElig;
    logic [NUM_OF_BDS_WIDTH-1:0] rotIdx;

    // Bit gi of rotElig is the descriptor gi+1 positions after rrPtr.
    generate
        for (genvar gi = 0; gi < NUM_OF_BDS; gi++) begin : gRot
            localparam logic [NUM_OF_BDS_WIDTH-1:0] OFFSET = NUM_OF_BDS_WIDTH'(gi + 1);
            assign rotElig[gi] = elig[rrPtr + OFFSET];
        end
    endgenerate

    always_comb begin
        rotIdx = '0;
        for (int i = NUM_OF_BDS - 1; i >= 0; i--) begin
            if (rotElig[i]) begin
                rotIdx = NUM_OF_BDS_WIDTH'(i);
            end
        end
    end

    assign pickNum = rrPtr + NUM_OF_BDS_WIDTH'(1) + rotIdx;
    assign pickVld = |elig;

endmodule

// File: rtl/dscrptr_req_sched.sv
// Picks the next eligible cached descriptor, reads it and hands it to DMATranCtrl.
module dscrptr_req_sched
    import dscrptr_req_sched_pkg::*;
#(
    parameter int NUM_OF_BDS        = 4,
    parameter int NUM_OF_BDS_WIDTH  = 2,
    parameter int DSCRPTR_OUT_WIDTH = 166,
    parameter int RD_LAT            = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_OF_BDS-1:0]        dscrptrValid,
    input  logic [NUM_OF_BDS-1:0]        extDscrptr,
    input  logic                         haltReq,
    output logic [NUM_OF_BDS_WIDTH-1:0]  dscrptrRdAddr,
    output logic                         rdEn_intext,
    input  logic [DSCRPTR_OUT_WIDTH-1:0] dscrptrDataOut,
    output logic                         reqValid,
    input  logic                         reqReady,
    output logic [NUM_OF_BDS_WIDTH-1:0]  reqDscrptrNum,
    output logic [DSCRPTR_OUT_WIDTH-1:0] reqData,
    input  logic                         tranDone,
    output logic                         busy
);

    localparam int CNT_W = (clog2(RD_LAT) < 1) ? 1 : clog2(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    schedStateT                   stateReg, stateNext;
    logic [CNT_W-1:0]             cntReg, cntNext;
    logic [NUM_OF_BDS_WIDTH-1:0]  rrPtrReg, rrPtrNext;
    logic [NUM_OF_BDS_WIDTH-1:0]  rdAddrReg, rdAddrNext;
    logic                         rdEnReg, rdEnNext;
    logic                         reqValidReg, reqValidNext;
    logic [NUM_OF_BDS_WIDTH-1:0]  reqNumReg, reqNumNext;
    logic [DSCRPTR_OUT_WIDTH-1:0] reqDataReg, reqDataNext;
    logic [NUM_OF_BDS_WIDTH-1:0]  pickNum;
    logic                         pickVld;

    dscrptr_rr_pick #(
        .NUM_OF_BDS       (NUM_OF_BDS),
        .NUM_OF_BDS_WIDTH (NUM_OF_BDS_WIDTH)
    ) uPick (
        .elig    (dscrptrValid | extDscrptr),
        .rrPtr   (rrPtrReg),
        .pickNum (pickNum),
        .pickVld (pickVld)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            rrPtrReg    <= NUM_OF_BDS_WIDTH'(NUM_OF_BDS - 1);
            rdAddrReg   <= '0;
            rdEnReg     <= 1'b0;
            reqValidReg <= 1'b0;
            reqNumReg   <= '0;
            reqDataReg  <= '0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            rrPtrReg    <= rrPtrNext;
            rdAddrReg   <= rdAddrNext;
            rdEnReg     <= rdEnNext;
            reqValidReg <= reqValidNext;
            reqNumReg   <= reqNumNext;
            reqDataReg  <= reqDataNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        rrPtrNext    = rrPtrReg;
        rdAddrNext   = rdAddrReg;
        rdEnNext     = 1'b0;
        reqValidNext = reqValidReg;
        reqNumNext   = reqNumReg;
        reqDataNext  = reqDataReg;
        case (stateReg)
            IDLE: begin
                if (!haltReq && pickVld) begin
                    rdAddrNext = pickNum;
                    reqNumNext = pickNum;
                    rdEnNext   = 1'b1;
                    cntNext    = CNT_LOAD;
                    stateNext  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // The pick is committed here; eligibility changes no longer matter.
                if (cntReg == '0) begin
                    reqDataNext  = dscrptrDataOut;
                    reqValidNext = 1'b1;
                    stateNext    = REQ;
                end else begin
                    cntNext = cntReg - CNT_W'(1);
                end
            end
            REQ: begin
                if (reqValidReg && reqReady) begin
                    reqValidNext = 1'b0;
                    rrPtrNext    = reqNumReg;
                    stateNext    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tranDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign dscrptrRdAddr = rdAddrReg;
    assign rdEn_intext   = rdEnReg;
    assign reqValid      = reqValidReg;
    assign reqDscrptrNum = reqNumReg;
    assign reqData       = reqDataReg;
    assign busy          = (stateReg != IDLE);

endmodule
